keypad_scanner: RTL and testbench

//  Scans a 4x4 matrix keypad and produces the debounced 4-bit key code consumed by the

---
 rtl/keypad_scanner.sv | 219 +++++++++++++++++++++
 tb/tb_keypad_scanner.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 active-low matrix keypad one column at a time,
// resolves each full scan to a single digit (or NO_KEY), and debounces the
// result over several consecutive scans before presenting it on key.
module keypad_scanner #(
  parameter int unsigned SCAN_DIV       = 250,
  parameter int unsigned DEBOUNCE_SCANS = 4,
  parameter logic [3:0]  NO_KEY         = 4'd10
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key,
  output logic       key_strobe
);

  localparam int unsigned   DW       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned   CW       = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_e;

  // Returns {valid, digit} for the key at (row r, column c); letters, * and # are not digits.
  function automatic logic [4:0] key_lookup(input logic [1:0] r, input logic [1:0] c);
    case ({r, c})
      4'h0:    key_lookup = {1'b1, 4'd1};
      4'h1:    key_lookup = {1'b1, 4'd2};
      4'h2:    key_lookup = {1'b1, 4'd3};
      4'h4:    key_lookup = {1'b1, 4'd4};
      4'h5:    key_lookup = {1'b1, 4'd5};
      4'h6:    key_lookup = {1'b1, 4'd6};
      4'h8:    key_lookup = {1'b1, 4'd7};
      4'h9:    key_lookup = {1'b1, 4'd8};
      4'hA:    key_lookup = {1'b1, 4'd9};
      4'hD:    key_lookup = {1'b1, 4'd0};
      default: key_lookup = {1'b0, 4'd0};
    endcase
  endfunction

  logic [3:0]    sync1_q, sync2_q;
  logic [DW-1:0] div_q, div_d;
  logic [1:0]    idx_q, idx_d;
  logic [3:0]    col_q, col_d;
  logic [1:0]    hits_q, hits_d;    // digit keys seen so far this scan, saturating at 2
  logic [3:0]    code_q, code_d;    // most recent digit seen this scan
  logic [4:0]    lk_s;
  logic [2:0]    col_hits_s;
  logic [3:0]    col_code_s;
  logic [2:0]    total_s;
  logic          scan_done_s;
  logic [3:0]    raw_s;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc_s;
  logic [3:0]    cand_q, cand_d;
  logic [3:0]    key_q, key_d;
  logic          strobe_q, strobe_d;

  // Two-flop synchronizer for the asynchronous row inputs (idle rows read high).
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_q <= 4'b1111;
      sync2_q <= 4'b1111;
    end else begin
      sync1_q <= row;
      sync2_q <= sync1_q;
    end
  end

  // Column timing, per-column row decode and per-scan accumulation into a raw result.
  always_comb begin
    div_d       = div_q + DW'(1);
    idx_d       = idx_q;
    col_d       = col_q;
    hits_d      = hits_q;
    code_d      = code_q;
    scan_done_s = 1'b0;
    raw_s       = NO_KEY;
    lk_s        = 5'd0;
    col_hits_s  = 3'd0;
    col_code_s  = code_q;
    for (int r = 0; r < 4; r++) begin
      lk_s = key_lookup(2'(r), idx_q);
      if (!sync2_q[r] && lk_s[4]) begin
        col_hits_s = col_hits_s + 3'd1;
        col_code_s = lk_s[3:0];
      end else begin
        col_hits_s = col_hits_s;
      end
    end
    total_s = {1'b0, hits_q} + col_hits_s;
    if (div_q == DIV_LAST) begin
      div_d = {DW{1'b0}};
      idx_d = idx_q + 2'd1;
      col_d = ~(4'b0001 << idx_d);
      if (idx_q == 2'd3) begin
        // Column 3 closes the scan: exactly one digit key gives that digit.
        scan_done_s = 1'b1;
        raw_s       = (total_s == 3'd1) ? col_code_s : NO_KEY;
        hits_d      = 2'd0;
        code_d      = NO_KEY;
      end else begin
        hits_d = (total_s >= 3'd2) ? 2'd2 : total_s[1:0];
        code_d = col_code_s;
      end
    end else begin
      div_d = div_q + DW'(1);
    end
  end

  // Scan divider, column drive and scan accumulator registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      div_q  <= {DW{1'b0}};
      idx_q  <= 2'd0;
      col_q  <= 4'b1110;
      hits_q <= 2'd0;
      code_q <= NO_KEY;
    end else begin
      div_q  <= div_d;
      idx_q  <= idx_d;
      col_q  <= col_d;
      hits_q <= hits_d;
      code_q <= code_d;
    end
  end

  // Debounce next-state: a digit must repeat for CNT_MAX closed scans to be accepted or released.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cand_d    = cand_q;
    key_d     = key_q;
    strobe_d  = 1'b0;
    cnt_inc_s = (cnt_q < CNT_MAX) ? (cnt_q + CW'(1)) : cnt_q;
    if (scan_done_s) begin
      case (state_q)
        IDLE: begin
          if (raw_s != NO_KEY) begin
            cand_d  = raw_s;
            cnt_d   = CW'(1);
            state_d = PRESS_WAIT;
          end else begin
            state_d = IDLE;
          end
        end
        PRESS_WAIT: begin
          if (raw_s == cand_q) begin
            cnt_d = cnt_inc_s;
            if (cnt_inc_s == CNT_MAX) begin
              state_d  = PRESSED;
              key_d    = cand_q;
              strobe_d = 1'b1;
            end else begin
              state_d = PRESS_WAIT;
            end
          end else begin
            state_d = IDLE;
          end
        end
        PRESSED: begin
          if (raw_s != cand_q) begin
            cnt_d   = CW'(1);
            state_d = RELEASE_WAIT;
          end else begin
            state_d = PRESSED;
          end
        end
        RELEASE_WAIT: begin
          if (raw_s == cand_q) begin
            state_d = PRESSED;
          end else begin
            cnt_d = cnt_inc_s;
            if (cnt_inc_s == CNT_MAX) begin
              state_d = IDLE;
              key_d   = NO_KEY;
            end else begin
              state_d = RELEASE_WAIT;
            end
          end
        end
        default: begin
          state_d = IDLE;
          key_d   = NO_KEY;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Debounce state and registered key outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= {CW{1'b0}};
      cand_q   <= NO_KEY;
      key_q    <= NO_KEY;
      strobe_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cand_q   <= cand_d;
      key_q    <= key_d;
      strobe_q <= strobe_d;
    end
  end

  assign col        = col_q;
  assign key        = key_q;
  assign key_strobe = strobe_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Testbench for keypad_scanner: a keypad model turns a pressed-key mask into
// row levels; a per-scan reference model derived from the debounce rules
// predicts key and key_strobe at every scan close.
module tb_keypad_scanner;

  localparam int SD   = 4;
  localparam int DB   = 3;
  localparam int SCAN = 4 * SD;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [3:0]  key;
  logic        key_strobe;
  logic [15:0] mask = 16'h0000;

  int passed = 0;
  int total  = 0;
  int strobe_seen = 0;

  // Reference model state
  int m_key    = 10;
  int m_cand   = 10;
  int m_streak = 0;
  int m_rel    = 0;
  bit m_strobe = 1'b0;

  // Key at index r*4+c; -1 marks keys that are not digits.
  int keymap [16] = '{1, 2, 3, -1, 4, 5, 6, -1, 7, 8, 9, -1, -1, 0, -1, -1};

  keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DB), .NO_KEY(4'd10)) dut (
    .clock(clock), .reset(reset), .row(row), .col(col), .key(key), .key_strobe(key_strobe)
  );

  always #5 clock = ~clock;

  // Keypad matrix: a pressed key pulls its row low while its column is driven low.
  always_comb begin
    row = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (mask[r*4+c] && (col[c] === 1'b0)) row[r] = 1'b0;
  end

  function automatic int raw_of(input logic [15:0] m);
    int n;
    int code;
    n = 0;
    code = 10;
    for (int i = 0; i < 16; i++) begin
      if (m[i] && keymap[i] >= 0) begin
        n++;
        code = keymap[i];
      end
    end
    return (n == 1) ? code : 10;
  endfunction

  function automatic logic [15:0] kb(input int i);
    logic [15:0] one;
    one = 16'h0001;
    return one << i;
  endfunction

  task automatic model_reset();
    m_key = 10; m_cand = 10; m_streak = 0; m_rel = 0; m_strobe = 1'b0;
  endtask

  // Apply one closed scan result to the debounce rules.
  task automatic model_scan(input int raw);
    m_strobe = 1'b0;
    if (m_key == 10) begin
      if (m_streak == 0) begin
        if (raw != 10) begin m_cand = raw; m_streak = 1; end
      end else if (raw == m_cand) begin
        m_streak++;
        if (m_streak == DB) begin m_key = m_cand; m_strobe = 1'b1; m_rel = 0; end
      end else begin
        m_streak = 0;
      end
    end else begin
      if (raw == m_key) m_rel = 0;
      else begin
        m_rel++;
        if (m_rel == DB) begin m_key = 10; m_streak = 0; end
      end
    end
  endtask

  // Hold mask for one full scan, starting at a scan boundary (negedge after the closing edge).
  task automatic do_scan(input logic [15:0] m, input string tag);
    int raw;
    int mid_strobes;
    logic [3:0] exp_col;
    mask = m;
    raw = raw_of(m);
    mid_strobes = 0;
    for (int j = 1; j <= SCAN; j++) begin
      @(posedge clock);
      @(negedge clock);
      exp_col = ~(4'b0001 << ((j / SD) % 4));
      total++;
      if (col !== exp_col) $display("FAIL %s col step %0d: got %b want %b", tag, j, col, exp_col);
      else passed++;
      if (key_strobe === 1'b1) strobe_seen++;
      if (j < SCAN && key_strobe !== 1'b0) mid_strobes++;
    end
    model_scan(raw);
    total++;
    if (key !== 4'(m_key)) $display("FAIL %s key: got %0d want %0d", tag, key, m_key);
    else passed++;
    total++;
    if (key_strobe !== m_strobe) $display("FAIL %s strobe: got %b want %b", tag, key_strobe, m_strobe);
    else passed++;
    total++;
    if (mid_strobes != 0) $display("FAIL %s stray strobe: got %0d want 0", tag, mid_strobes);
    else passed++;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    mask = 16'h0000;
    repeat (3) @(negedge clock);
    total++; if (col !== 4'b1110) $display("FAIL reset col: got %b want 1110", col); else passed++;
    total++; if (key !== 4'd10) $display("FAIL reset key: got %0d want 10", key); else passed++;
    total++; if (key_strobe !== 1'b0) $display("FAIL reset strobe: got %b want 0", key_strobe); else passed++;
    reset = 1'b1;
    model_reset();
    repeat (2) do_scan(16'h0000, "reset_idle");
  endtask

  task automatic test_clean_press();
    strobe_seen = 0;
    repeat (8) do_scan(kb(5), "press5");
    total++; if (key !== 4'd5) $display("FAIL press5 held key: got %0d want 5", key); else passed++;
    total++; if (strobe_seen != 1) $display("FAIL press5 strobes: got %0d want 1", strobe_seen); else passed++;
    strobe_seen = 0;
    repeat (2) do_scan(16'h0000, "rel5");
    total++; if (key !== 4'd5) $display("FAIL rel5 early key: got %0d want 5", key); else passed++;
    do_scan(16'h0000, "rel5");
    total++; if (key !== 4'd10) $display("FAIL rel5 key: got %0d want 10", key); else passed++;
    total++; if (strobe_seen != 0) $display("FAIL rel5 strobes: got %0d want 0", strobe_seen); else passed++;
  endtask

  task automatic test_bounce();
    strobe_seen = 0;
    do_scan(kb(8), "bounce7");
    do_scan(16'h0000, "bounce7");
    do_scan(kb(8), "bounce7");
    do_scan(kb(8), "bounce7");
    total++; if (key !== 4'd10) $display("FAIL bounce7 early key: got %0d want 10", key); else passed++;
    do_scan(kb(8), "bounce7");
    total++; if (key !== 4'd7) $display("FAIL bounce7 key: got %0d want 7", key); else passed++;
    repeat (3) do_scan(kb(8), "bounce7");
    total++; if (strobe_seen != 1) $display("FAIL bounce7 strobes: got %0d want 1", strobe_seen); else passed++;
    repeat (3) do_scan(16'h0000, "rel7");
  endtask

  task automatic test_multi_key();
    strobe_seen = 0;
    repeat (6) do_scan(kb(0) | kb(1), "multi12");
    total++; if (key !== 4'd10) $display("FAIL multi12 key: got %0d want 10", key); else passed++;
    total++; if (strobe_seen != 0) $display("FAIL multi12 strobes: got %0d want 0", strobe_seen); else passed++;
    repeat (3) do_scan(kb(0), "only1");
    total++; if (key !== 4'd1) $display("FAIL only1 key: got %0d want 1", key); else passed++;
    total++; if (strobe_seen != 1) $display("FAIL only1 strobes: got %0d want 1", strobe_seen); else passed++;
    repeat (3) do_scan(16'h0000, "rel1");
  endtask

  task automatic test_ignored_and_rollover();
    strobe_seen = 0;
    repeat (6) do_scan(kb(3), "keyA");
    repeat (6) do_scan(kb(14), "keyHash");
    total++; if (key !== 4'd10) $display("FAIL letters key: got %0d want 10", key); else passed++;
    total++; if (strobe_seen != 0) $display("FAIL letters strobes: got %0d want 0", strobe_seen); else passed++;
    repeat (4) do_scan(kb(13), "hold0");
    total++; if (key !== 4'd0) $display("FAIL hold0 key: got %0d want 0", key); else passed++;
    repeat (3) do_scan(kb(13) | kb(10), "roll09");
    total++; if (key !== 4'd10) $display("FAIL roll09 key: got %0d want 10", key); else passed++;
    strobe_seen = 0;
    repeat (3) do_scan(kb(10), "only9");
    total++; if (key !== 4'd9) $display("FAIL only9 key: got %0d want 9", key); else passed++;
    total++; if (strobe_seen != 1) $display("FAIL only9 strobes: got %0d want 1", strobe_seen); else passed++;
    repeat (3) do_scan(16'h0000, "rel9");
  endtask

  task automatic test_random();
    logic [15:0] m;
    m = 16'h0000;
    for (int s = 0; s < 60; s++) begin
      if ($urandom_range(0, 9) >= 6) begin
        case ($urandom_range(0, 3))
          0:       m = 16'h0000;
          1:       m = kb($urandom_range(0, 15));
          2:       m = kb($urandom_range(0, 15)) | kb($urandom_range(0, 15));
          default: m = kb(13 - 13 * int'($urandom_range(0, 1)) + int'($urandom_range(0, 2)) * 4);
        endcase
      end
      do_scan(m, "random");
    end
    repeat (DB + 1) do_scan(16'h0000, "random_rel");
  endtask

  task automatic test_reset_mid();
    repeat (DB + 1) do_scan(kb(2), "hold3");
    total++; if (key !== 4'd3) $display("FAIL hold3 key: got %0d want 3", key); else passed++;
    @(posedge clock);
    #2 reset = 1'b0;
    #1;
    total++; if (key !== 4'd10) $display("FAIL midrst key: got %0d want 10", key); else passed++;
    total++; if (col !== 4'b1110) $display("FAIL midrst col: got %b want 1110", col); else passed++;
    total++; if (key_strobe !== 1'b0) $display("FAIL midrst strobe: got %b want 0", key_strobe); else passed++;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    model_reset();
    strobe_seen = 0;
    repeat (DB + 2) do_scan(kb(2), "redeb3");
    total++; if (key !== 4'd3) $display("FAIL redeb3 key: got %0d want 3", key); else passed++;
    total++; if (strobe_seen != 1) $display("FAIL redeb3 strobes: got %0d want 1", strobe_seen); else passed++;
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_multi_key();
    test_ignored_and_rollover();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
